// File: rtl/cdb_arbiter_if.sv
// ---------------------------------------------------------------------------
// cdb_arbiter_if : producer-side results and CDB broadcast lanes
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface cdb_arbiter_if #(
   parameter int NUM_REQ   = 4,
   parameter int NUM_LANES = 2,
   parameter int ROB_DEPTH = 4
);
   logic                                 flush;
   logic [NUM_REQ-1:0]                   req_valid;
   logic [NUM_REQ-1:0][31:0]             req_rd_v;
   logic [NUM_REQ-1:0][ROB_DEPTH-1:0]    req_rob;
   logic [NUM_REQ-1:0]                   req_ready;
   logic [NUM_LANES-1:0]                 cdb_valid;
   logic [NUM_LANES-1:0][31:0]           cdb_rd_v;
   logic [NUM_LANES-1:0][ROB_DEPTH-1:0]  cdb_rob;

   modport master (
      output flush, req_valid, req_rd_v, req_rob,
      input  req_ready, cdb_valid, cdb_rd_v, cdb_rob
   );

   modport slave (
      input  flush, req_valid, req_rd_v, req_rob,
      output req_ready, cdb_valid, cdb_rd_v, cdb_rob
   );
endinterface

`default_nettype wire

// File: rtl/cdb_arbiter.sv
// ---------------------------------------------------------------------------
// cdb_arbiter : round-robin grant of NUM_REQ result producers onto NUM_LANES
//               registered common-data-bus lanes
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module cdb_arbiter #(
   parameter int NUM_REQ   = 4,
   parameter int NUM_LANES = 2,
   parameter int ROB_DEPTH = 4
) (
   input  logic         clk,
   input  logic         rst,
   cdb_arbiter_if.slave bus
);
   localparam int PTR_W  = (NUM_REQ   > 1) ? $clog2(NUM_REQ)   : 1;
   localparam int LANE_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

   logic [PTR_W-1:0]                     rr_ptr_q,    rr_ptr_d;
   logic [NUM_LANES-1:0]                 cdb_valid_q, cdb_valid_d;
   logic [NUM_LANES-1:0][31:0]           cdb_rd_v_q,  cdb_rd_v_d;
   logic [NUM_LANES-1:0][ROB_DEPTH-1:0]  cdb_rob_q,   cdb_rob_d;

   logic [NUM_REQ-1:0]                   granted;
   logic [NUM_LANES-1:0]                 lane_hit;
   logic [NUM_LANES-1:0][PTR_W-1:0]      lane_win;
   logic [PTR_W-1:0]                     last_win;
   logic [PTR_W:0]                       scan_sum;
   logic [PTR_W-1:0]                     scan_idx;
   logic [LANE_W:0]                      n_grant;

   // Scan from rr_ptr with an explicit modulo so non-power-of-two counts wrap correctly.
   always_comb begin
      granted  = '0;
      lane_hit = '0;
      lane_win = '0;
      last_win = rr_ptr_q;
      n_grant  = '0;
      scan_sum = '0;
      scan_idx = '0;
      for (int j = 0; j < NUM_REQ; j++) begin
         scan_sum = {1'b0, rr_ptr_q} + (PTR_W+1)'(j);
         if (scan_sum >= (PTR_W+1)'(NUM_REQ)) begin
            scan_sum = scan_sum - (PTR_W+1)'(NUM_REQ);
         end
         scan_idx = scan_sum[PTR_W-1:0];
         if (bus.req_valid[scan_idx] && (n_grant < (LANE_W+1)'(NUM_LANES))) begin
            granted[scan_idx]               = 1'b1;
            lane_hit[n_grant[LANE_W-1:0]]   = 1'b1;
            lane_win[n_grant[LANE_W-1:0]]   = scan_idx;
            last_win                        = scan_idx;
            n_grant                         = n_grant + (LANE_W+1)'(1);
         end
      end
   end

   always_comb begin
      rr_ptr_d    = rr_ptr_q;
      cdb_valid_d = '0;
      cdb_rd_v_d  = cdb_rd_v_q;
      cdb_rob_d   = cdb_rob_q;
      if (!bus.flush) begin
         for (int k = 0; k < NUM_LANES; k++) begin
            if (lane_hit[k]) begin
               cdb_valid_d[k] = 1'b1;
               cdb_rd_v_d[k]  = bus.req_rd_v[lane_win[k]];
               cdb_rob_d[k]   = bus.req_rob[lane_win[k]];
            end
         end
         if (|granted) begin
            rr_ptr_d = (last_win == PTR_W'(NUM_REQ - 1)) ? '0 : last_win + PTR_W'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rr_ptr_q    <= '0;
         cdb_valid_q <= '0;
         cdb_rd_v_q  <= '0;
         cdb_rob_q   <= '0;
      end else begin
         rr_ptr_q    <= rr_ptr_d;
         cdb_valid_q <= cdb_valid_d;
         cdb_rd_v_q  <= cdb_rd_v_d;
         cdb_rob_q   <= cdb_rob_d;
      end
   end

   assign bus.req_ready = granted & {NUM_REQ{~bus.flush}};
   assign bus.cdb_valid = cdb_valid_q;
   assign bus.cdb_rd_v  = cdb_rd_v_q;
   assign bus.cdb_rob   = cdb_rob_q;

endmodule

`default_nettype wire

// File: tb/tb_cdb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_cdb_arbiter : directed self-checking bench for cdb_arbiter (4 req, 2 lanes)
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_cdb_arbiter;
   logic clk;
   logic rst;
   int   checks;
   int   failures;
   int   miss;
   int   max_miss;

   cdb_arbiter_if #(.NUM_REQ(4), .NUM_LANES(2), .ROB_DEPTH(4)) bus ();

   cdb_arbiter #(.NUM_REQ(4), .NUM_LANES(2), .ROB_DEPTH(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Default producer payloads: value (i+1)*0x11111111, tag 3*i+1.
   task automatic load_defaults();
      for (int i = 0; i < 4; i++) begin
         bus.req_rd_v[i] = 32'h1111_1111 * (i + 1);
         bus.req_rob[i]  = 4'(3 * i + 1);
      end
   endtask

   task automatic lanes(input string tag, input logic [1:0] v,
                        input logic [31:0] d0, input logic [3:0] t0,
                        input logic [31:0] d1, input logic [3:0] t1);
      chk({tag, "_valid"}, 64'(bus.cdb_valid), 64'(v));
      if (v[0]) begin
         chk({tag, "_l0_rdv"}, 64'(bus.cdb_rd_v[0]), 64'(d0));
         chk({tag, "_l0_rob"}, 64'(bus.cdb_rob[0]),  64'(t0));
      end
      if (v[1]) begin
         chk({tag, "_l1_rdv"}, 64'(bus.cdb_rd_v[1]), 64'(d1));
         chk({tag, "_l1_rob"}, 64'(bus.cdb_rob[1]),  64'(t1));
      end
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      miss     = 0;
      max_miss = 0;
      rst       = 1'b1;
      bus.flush = 1'b0;
      load_defaults();
      bus.req_valid = 4'($urandom);

      // Reset with arbitrary requests
      repeat (2) @(posedge clk);
      #1;
      chk("rst_valid", 64'(bus.cdb_valid), 64'h0);
      chk("rst_rdv",   64'(bus.cdb_rd_v),  64'h0);
      chk("rst_rob",   64'(bus.cdb_rob),   64'h0);
      chk("rst_ptr",   64'(dut.rr_ptr_q),  64'h0);

      // Single requester 2 after reset
      @(negedge clk);
      rst = 1'b0;
      bus.req_valid = 4'b0100;
      bus.req_rd_v[2] = 32'hDEAD_BEEF;
      bus.req_rob[2]  = 4'd5;
      #1 chk("single_ready", 64'(bus.req_ready), 64'h4);
      @(posedge clk); #1;
      lanes("single", 2'b01, 32'hDEAD_BEEF, 4'd5, 32'h0, 4'd0);
      chk("single_ptr", 64'(dut.rr_ptr_q), 64'h3);
      load_defaults();

      // All valid from rr_ptr=3: {3,0} then {1,2}
      @(negedge clk);
      bus.req_valid = 4'b1111;
      #1 chk("allv_a_ready", 64'(bus.req_ready), 64'h9);
      @(posedge clk); #1;
      lanes("allv_a", 2'b11, 32'h4444_4444, 4'd10, 32'h1111_1111, 4'd1);
      chk("allv_a_ptr", 64'(dut.rr_ptr_q), 64'h1);
      @(negedge clk);
      #1 chk("allv_b_ready", 64'(bus.req_ready), 64'h6);
      @(posedge clk); #1;
      lanes("allv_b", 2'b11, 32'h2222_2222, 4'd4, 32'h3333_3333, 4'd7);
      chk("allv_b_ptr", 64'(dut.rr_ptr_q), 64'h3);

      // Wrap: ptr=3, requesters 0 and 3
      @(negedge clk);
      bus.req_valid = 4'b1001;
      #1 chk("wrap_ready", 64'(bus.req_ready), 64'h9);
      @(posedge clk); #1;
      lanes("wrap", 2'b11, 32'h4444_4444, 4'd10, 32'h1111_1111, 4'd1);
      chk("wrap_ptr", 64'(dut.rr_ptr_q), 64'h1);

      // Flush: cycle N-1 grants {1,2}, cycle N flushes
      @(negedge clk);
      bus.req_valid = 4'b1111;
      #1 chk("preflush_ready", 64'(bus.req_ready), 64'h6);
      @(posedge clk);
      @(negedge clk);
      bus.flush = 1'b1;
      #1 chk("flush_ready", 64'(bus.req_ready), 64'h0);
      lanes("flush_n", 2'b11, 32'h2222_2222, 4'd4, 32'h3333_3333, 4'd7);
      @(posedge clk); #1;
      chk("flush_n1_valid", 64'(bus.cdb_valid), 64'h0);
      chk("flush_rob_hold", 64'(bus.cdb_rob),   64'h74);
      chk("flush_ptr",      64'(dut.rr_ptr_q),  64'h3);

      // No requesters
      @(negedge clk);
      bus.flush = 1'b0;
      bus.req_valid = 4'b0000;
      #1 chk("idle_ready", 64'(bus.req_ready), 64'h0);
      @(posedge clk); #1;
      chk("idle_valid", 64'(bus.cdb_valid), 64'h0);
      chk("idle_ptr",   64'(dut.rr_ptr_q),  64'h3);

      // Fewer valid than lanes: scan 3,0,1 finds only req 1
      @(negedge clk);
      bus.req_valid = 4'b0010;
      #1 chk("few_ready", 64'(bus.req_ready), 64'h2);
      @(posedge clk); #1;
      lanes("few", 2'b01, 32'h2222_2222, 4'd4, 32'h0, 4'd0);
      chk("few_ptr", 64'(dut.rr_ptr_q), 64'h2);

      // Async reset between edges while lanes carry {2,3}
      @(negedge clk);
      bus.req_valid = 4'b1111;
      #1 chk("pre_arst_ready", 64'(bus.req_ready), 64'hC);
      @(posedge clk); #2;
      chk("pre_arst_valid", 64'(bus.cdb_valid), 64'h3);
      rst = 1'b1;
      #1;
      chk("arst_valid", 64'(bus.cdb_valid), 64'h0);
      chk("arst_rdv",   64'(bus.cdb_rd_v),  64'h0);
      chk("arst_ptr",   64'(dut.rr_ptr_q),  64'h0);
      chk("arst_ready", 64'(bus.req_ready), 64'h3);
      @(negedge clk);
      rst = 1'b0;

      // Continuous all-valid from ptr=0: {0,1}, {2,3}, {0,1}
      #1 chk("rr0_ready", 64'(bus.req_ready), 64'h3);
      @(posedge clk); #1;
      lanes("rr0", 2'b11, 32'h1111_1111, 4'd1, 32'h2222_2222, 4'd4);
      chk("rr0_ptr", 64'(dut.rr_ptr_q), 64'h2);
      @(negedge clk);
      #1 chk("rr1_ready", 64'(bus.req_ready), 64'hC);
      @(posedge clk); #1;
      lanes("rr1", 2'b11, 32'h3333_3333, 4'd7, 32'h4444_4444, 4'd10);
      chk("rr1_ptr", 64'(dut.rr_ptr_q), 64'h0);
      @(negedge clk);
      #1 chk("rr2_ready", 64'(bus.req_ready), 64'h3);
      @(posedge clk); #1;
      lanes("rr2", 2'b11, 32'h1111_1111, 4'd1, 32'h2222_2222, 4'd4);

      // Starvation: req 1 always valid, others random
      for (int c = 0; c < 1000; c++) begin
         @(negedge clk);
         bus.req_valid = {1'($urandom), 1'($urandom), 1'b1, 1'($urandom)};
         #1;
         if (bus.req_ready[1]) begin
            miss = 0;
         end else begin
            miss++;
            if (miss > max_miss) max_miss = miss;
         end
      end
      chk("starve_max_wait_gt1", 64'(max_miss > 1), 64'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

`default_nettype wire

// File: doc/cdb_arbiter.md
# cdb_arbiter

Round-robin arbiter that shares a small number of common-data-bus (CDB) lanes among a larger number of execution-unit result producers. Each producer presents a result (value and ROB tag) with a valid/ready handshake. Each cycle the arbiter grants up to NUM_LANES of them and registers the winners onto the CDB lanes. The lanes are consumed by the reservation stations, the ROB and the register-file wakeup logic.

## Interface
- NUM_REQ, 4: number of requesting execution units; ≥ 2.
- NUM_LANES, 2: number of CDB broadcast lanes; 1 ≤ NUM_LANES ≤ NUM_REQ.
- ROB_DEPTH, 4: bit width of the ROB tag.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  pipeline flush (mispredict); synchronous.
- req_valid[NUM_REQ]  in  1 each  producer i holds a result.
- req_rd_v[NUM_REQ]  in  32 each  result value.
- req_rob[NUM_REQ]  in  ROB_DEPTH each  destination ROB tag.
- req_ready[NUM_REQ]  out  1 each  producer i granted this cycle; the result is consumed at the clock edge.
- cdb_valid[NUM_LANES]  out  1 each  lane carries a broadcast.
- cdb_rd_v[NUM_LANES]  out  32 each  broadcast value.
- cdb_rob[NUM_LANES]  out  ROB_DEPTH each  broadcast ROB tag.

## Operation
- State:
  - rr_ptr, $clog2(NUM_REQ) bits: highest-priority requester.
  - Lane output registers for cdb_valid, cdb_rd_v and cdb_rob.
- Grant selection (combinational):
  - Scan indices rr_ptr, rr_ptr+1, … mod NUM_REQ.
  - The first NUM_LANES with req_valid=1 are granted in scan order.
  - The k-th granted requester maps to lane k (k = 0 upward).
- req_ready[i] = granted[i] & ~flush.
  - req_ready may depend combinationally on req_valid.
  - req_valid must not depend on req_ready.
- Producer hold rule: a producer with valid=1 and ready=0 holds its valid, value and tag stable until granted or until flush.
- Lane register update at the clock edge:
  - If flush=1: all cdb_valid <= 0; rd_v and rob hold.
  - Else, for each lane k that has a grant: cdb_valid[k] <= 1, cdb_rd_v[k] <= req_rd_v[winner], cdb_rob[k] <= req_rob[winner].
  - Else, for each lane k with no grant: cdb_valid[k] <= 0; rd_v and rob hold.
- rr_ptr update at the clock edge:
  - If at least one grant and no flush: rr_ptr <= (index of last granted requester + 1) mod NUM_REQ.
  - Otherwise rr_ptr holds.
- No internal result buffering: an ungranted result stays in the producer.
- Fairness: a continuously valid requester is granted within ceil(NUM_REQ/NUM_LANES) cycles.
- No error detection. Duplicate ROB tags on different lanes are passed through unchanged.

## Timing
- Reset (asynchronous, immediate on rst=1):
  - cdb_valid all 0, cdb_rd_v all 0, cdb_rob all 0, rr_ptr 0.
  - req_ready follows its combinational definition using rr_ptr=0.
- Latency: request granted in cycle N → on CDB lane in cycle N+1, held for exactly one cycle unless re-granted.
- Throughput: up to NUM_LANES results per cycle, with no bubbles between back-to-back grants.
- Fewer valid requesters than lanes: all are granted; unused high lanes drive valid=0.
- No valid requesters: all lanes valid=0 next cycle; rr_ptr unchanged.
- Wrap-around: the scan crosses from index NUM_REQ-1 to index 0. rr_ptr wraps modulo NUM_REQ, including when NUM_REQ is not a power of two.
- Flush in cycle N:
  - No grants in cycle N.
  - Lanes are invalid in cycle N+1.
  - A broadcast already on the lanes in cycle N completes normally.
- Flush and rst together: rst dominates.
- Reset asserted mid-operation: lanes clear immediately. Any producer that was granted in that cycle loses its result; re-issue after reset is the producer's responsibility.

## Test plan
- Reset: hold rst with random requests → all cdb_valid=0, cdb_rd_v=0, cdb_rob=0. After release with only req_valid[2]=1 (value 0xDEAD_BEEF, rob 5) → req_ready[2]=1; next cycle lane 0 valid with 0xDEADBEEF/5, lane 1 invalid.
- All 4 requesters valid continuously (defaults) → grants {0,1}, then {2,3}, then {0,1}. Each pair appears on lanes 0/1 in that order one cycle after its grant.
- Wrap: rr_ptr=3 (after granting {1,2}), requesters 0 and 3 valid → lane 0 = req 3, lane 1 = req 0; next rr_ptr=1.
- Flush: valid requests with flush=1 in cycle N → req_ready all 0; lanes invalid at N+1; the lane contents from cycle N-1 grants still appear at N; rr_ptr unchanged.
- Starvation: req 1 held valid while reqs 0, 2 and 3 toggle randomly for 1000 cycles → req 1 waits at most 2 cycles per grant.
- Async reset mid-stream: assert rst between clock edges while lanes are valid → cdb_valid drops before the next edge; rr_ptr=0 afterwards.
